// File: rtl/control_pkg.sv
// control_pkg: state encoding, ISA field constants and per-state datapath controls
// shared by the multicycle main controller.
package control_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       nextpc;
        logic       branch;
    } ctrl_t;

    // Moore output table: everything not set here stays 0.
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            DECODE:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            MEMADR:   c.alusrcb = 2'b01;
            MEMRD:    c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = 2'b01; c.regw = 1'b1; end
            MEMWR:    begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECUTER: c.aluop = 1'b1;
            EXECUTEI: begin c.alusrcb = 2'b01; c.aluop = 1'b1; end
            ALUWB:    c.regw = 1'b1;
            BRANCH:   begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: maps ALUOp and the data-processing cmd/S bits to ALU function,
// flag-write mask and register-write suppression.
module alu_decoder
    import control_pkg::*;
(
    input  logic       aluop,
    input  logic [5:0] funct,
    output logic [1:0] alucontrol,
    output logic [1:0] flagw,
    output logic       nowrite
);
    logic [3:0] cmd;
    logic       s;
    logic       arith;
    logic       known;

    assign cmd   = funct[4:1];
    assign s     = funct[0];
    assign arith = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP;
    assign known = arith || cmd == CMD_AND || cmd == CMD_ORR;

    assign alucontrol = !aluop ? ALU_ADD :
                        (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
                        cmd == CMD_AND ? ALU_AND :
                        cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
    // Unsupported cmds behave as a flagless no-op.
    assign flagw   = aluop && known ? {s, s & arith} : 2'b00;
    assign nowrite = aluop && (cmd == CMD_CMP || !known);
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle main controller; state and all Moore controls are
// registered together so outputs only move after a clock edge.
module control_fsm
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       RegW,
    output logic       MemW,
    output logic       NextPC,
    output logic       PCS
);
    state_t state;
    state_t nxt;
    ctrl_t  ctl;

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:              nxt = DECODE;
            DECODE:             nxt = Op == OP_MEM ? MEMADR :
                                      Op == OP_BR  ? BRANCH :
                                      Op == OP_DP  ? (Funct[5] ? EXECUTEI : EXECUTER) : FETCH;
            MEMADR:             nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:              nxt = MEMWB;
            EXECUTER, EXECUTEI: nxt = ALUWB;
            default:            nxt = FETCH;
        endcase
    end

    // Controls are precomputed from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= ctrl_of(FETCH);
        end else begin
            state <= nxt;
            ctl   <= ctrl_of(nxt);
        end
    end

    alu_decoder u_alu (
        .aluop     (ctl.aluop),
        .funct     (Funct),
        .alucontrol(ALUControl),
        .flagw     (FlagW),
        .nowrite   (NoWrite)
    );

    assign IRWrite   = ctl.irwrite;
    assign AdrSrc    = ctl.adrsrc;
    assign ALUSrcA   = ctl.alusrca;
    assign ALUSrcB   = ctl.alusrcb;
    assign ResultSrc = ctl.resultsrc;
    assign RegW      = ctl.regw;
    assign MemW      = ctl.memw;
    assign NextPC    = ctl.nextpc;
    assign PCS       = ctl.branch | (ctl.regw & (Rd == 4'd15));
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main controller for the CPU control unit. It decodes instruction fields `Op`/`Funct`/`Rd` and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects directly. Its unconditioned write strobes (`RegW`, `MemW`, `PCS`, `NextPC`, `NoWrite`) and flag-write mask (`FlagW`) feed the condition-logic stage, which gates them with the condition check.

## Interface
Parameters: none. All widths are fixed by the ISA subset.
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-high; forces state to FETCH immediately
- `Op`  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
- `Funct`  input  6  instruction bits [25:20]: [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory)
- `Rd`  input  4  destination register; 15 means the PC
- `IRWrite`  output  1  load the instruction register
- `AdrSrc`  output  1  memory address select: 0 = PC, 1 = ALU result register
- `ALUSrcA`  output  1  ALU A select: 0 = register A, 1 = PC
- `ALUSrcB`  output  2  ALU B select: 00 = register, 01 = extended immediate, 10 = constant 4
- `ResultSrc`  output  2  result select: 00 = ALU output register, 01 = data register, 10 = ALU result
- `ALUControl`  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `FlagW`  output  2  flag-write request: [1] = N,Z, [0] = C,V
- `NoWrite`  output  1  suppress register write (CMP)
- `RegW`, `MemW`, `NextPC`  output  1 each  unconditioned write strobes
- `PCS`  output  1  PC-source request: Branch OR (RegW AND Rd==15)

## Operation
- Moore FSM. All mux selects and strobes are a pure function of the current state. `ALUControl`, `FlagW` and `NoWrite` also depend on `Funct`. Unlisted outputs are 0.
- FETCH: `IRWrite`=1, `NextPC`=1, `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, ALUOp=0.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
- MEMADR: `ALUSrcA`=0, `ALUSrcB`=01, ALUOp=0.
- MEMRD: `AdrSrc`=1, `ResultSrc`=00.
- MEMWB: `ResultSrc`=01, `RegW`=1.
- MEMWR: `AdrSrc`=1, `ResultSrc`=00, `MemW`=1.
- EXECUTER: `ALUSrcB`=00, ALUOp=1.
- EXECUTEI: `ALUSrcB`=01, ALUOp=1.
- ALUWB: `ResultSrc`=00, `RegW`=1.
- BRANCH: `ALUSrcB`=01, `ResultSrc`=10, Branch=1, ALUOp=0.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH, with no strobe asserted.
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECUTER or EXECUTEI→ALUWB→FETCH.
  - BRANCH→FETCH.
  - Any undefined state encoding→FETCH.
- ALU decode with ALUOp=0: `ALUControl`=00, `FlagW`=00, `NoWrite`=0.
- ALU decode with ALUOp=1, by cmd:
  - 0100 (ADD)→00.
  - 0010 (SUB)→01.
  - 0000 (AND)→10.
  - 1100 (ORR)→11.
  - 1010 (CMP)→01 with `NoWrite`=1.
  - Other cmd values→00 with `NoWrite`=1 and `FlagW`=00.
- Flag-write mask for supported cmds: `FlagW`[1]=S. `FlagW`[0]=S AND (cmd is ADD, SUB or CMP).
- `FlagW` is non-zero only in EXECUTER and EXECUTEI, so flags latch exactly once per data-processing instruction.
- `PCS` is asserted:
  - in BRANCH;
  - in ALUWB or MEMWB when Rd=15.

## Timing
- Reset: state=FETCH while `reset` is high and asynchronously on assertion. Outputs therefore show FETCH values during reset: `IRWrite`=1, `NextPC`=1, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, all others 0.
- The condition-logic stage masks `NextPC`/`IRWrite` effects during reset through its own reset.
- Reset mid-instruction: the instruction is abandoned. No write strobe is asserted in the cycle after deassertion except FETCH's.
- Cycles per instruction:
  - LDR: 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB).
  - STR: 4.
  - Data-processing: 4.
  - B: 3.
  - Illegal: 2.
- Outputs change only after a clock edge. `Funct`/`Rd` must be stable from DECODE to the end of the instruction; they are held by the instruction register.

## Structure
- Package `control_pkg`:
  - `state_t` enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
  - Op codes: OP_DP, OP_MEM, OP_BR.
  - cmd constants: CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP.
  - ALUControl encodings.
- Sub-module `alu_decoder`: combinational; inputs ALUOp, Funct; outputs `ALUControl`, `FlagW`, `NoWrite`.
- State register with async reset, next-state logic and output logic stay in `control_fsm`.

## Test plan
- Reset pulse mid-MEMRD → state=FETCH immediately; `IRWrite`=1; `RegW`=0; `MemW`=0.
- LDR (Op=01, Funct=011001, Rd=3) → 5 cycles. `RegW`=1 only in cycle 5, with `ResultSrc`=01. `PCS`=0.
- STR (Op=01, Funct=011000) → `MemW`=1 only in cycle 4, with `AdrSrc`=1. Then FETCH.
- SUBS immediate (Op=00, Funct=100101) → EXECUTEI with `ALUControl`=01 and `FlagW`=11. ALUWB with `RegW`=1. Rd=15 → `PCS`=1 in ALUWB.
- CMP register (Funct=010101) → `FlagW`=11, `NoWrite`=1 and `ALUControl`=01 in EXECUTER. ANDS → `FlagW`=10.
- B (Op=10) → `PCS`=1, `ALUSrcB`=01 in cycle 3. Op=11 → FETCH after DECODE with no strobes.
